// File: rtl/count_disp_pkg.sv
// Shared types, segment patterns and the double-dabble digit helper for count_bcd_display.
package count_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Pre-shift correction so a digit >= 5 carries correctly after doubling
  function automatic logic [3:0] add3_digit(input logic [3:0] d);
    return (d >= 4'd5) ? 4'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to seven segments; codes above 9 blank the digit.
module seg7_decode
  import count_disp_pkg::*;
#(
  parameter int unsigned SEG_ACT_LOW = 1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_BLANK;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

  assign seg = (SEG_ACT_LOW != 0) ? ~pattern : pattern;

endmodule

// File: rtl/count_bcd_display.sv
// Samples the counter value, converts it to BCD with a serial double-dabble engine,
// drives the seven-segment digits and tracks terminal-count wraps.
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DIGITS      = 5,
  parameter int unsigned AUTO_SAMPLE = 1,
  parameter int unsigned SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  tc_in,
  input  logic                  sample,
  input  logic                  clear_wrap,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex_n,
  output logic                  wrap_flag,
  output logic [7:0]            wrap_cnt
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SHW   = BCD_W + WIDTH;

  state_t             state, state_next;
  logic [WIDTH-1:0]   bin_q, bin_next;
  logic [WIDTH-1:0]   last_q, last_next;
  logic [BCD_W-1:0]   scratch_q, scratch_next, scratch_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic               pending_q, pending_next;
  logic [BCD_W-1:0]   bcd_q, bcd_next;
  logic               valid_q, valid_next;
  logic               busy_q, busy_next;
  logic               wrap_flag_q, wrap_flag_next;
  logic [7:0]         wrap_cnt_q, wrap_cnt_next;
  logic               request;
  logic [SHW-1:0]     shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q       <= '0;
      last_q      <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      bcd_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      wrap_flag_q <= 1'b0;
      wrap_cnt_q  <= '0;
    end else begin
      bin_q       <= bin_next;
      last_q      <= last_next;
      scratch_q   <= scratch_next;
      cnt_q       <= cnt_next;
      pending_q   <= pending_next;
      bcd_q       <= bcd_next;
      valid_q     <= valid_next;
      busy_q      <= busy_next;
      wrap_flag_q <= wrap_flag_next;
      wrap_cnt_q  <= wrap_cnt_next;
    end
  end

  // Next-state, conversion datapath and wrap tracking
  always_comb begin
    state_next     = state;
    bin_next       = bin_q;
    last_next      = last_q;
    scratch_next   = scratch_q;
    cnt_next       = cnt_q;
    pending_next   = pending_q;
    bcd_next       = bcd_q;
    valid_next     = 1'b0;
    wrap_flag_next = wrap_flag_q;
    wrap_cnt_next  = wrap_cnt_q;

    for (int i = 0; i < int'(DIGITS); i++) begin
      scratch_adj[4*i +: 4] = add3_digit(scratch_q[4*i +: 4]);
    end
    shifted = {scratch_adj, bin_q} << 1;

    request = sample || ((AUTO_SAMPLE != 0) && (count_in != last_q));

    case (state)
      ST_IDLE: begin
        if (request) begin
          bin_next     = count_in;
          last_next    = count_in;
          scratch_next = '0;
          cnt_next     = '0;
          state_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_next = shifted[SHW-1:WIDTH];
        bin_next     = shifted[WIDTH-1:0];
        cnt_next     = CNT_W'(cnt_q + 1'b1);
        if (sample) pending_next = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        bcd_next   = scratch_q;
        valid_next = 1'b1;
        // A request arriving on the DONE edge merges into the restart
        if (pending_q || sample) begin
          pending_next = 1'b0;
          bin_next     = count_in;
          last_next    = count_in;
          scratch_next = '0;
          cnt_next     = '0;
          state_next   = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);

    // tc takes priority over clear so a wrap on the clear edge is never lost
    if (tc_in) begin
      wrap_flag_next = 1'b1;
      if (clear_wrap)                wrap_cnt_next = 8'd1;
      else if (wrap_cnt_q != 8'hFF)  wrap_cnt_next = 8'(wrap_cnt_q + 8'd1);
    end else if (clear_wrap) begin
      wrap_flag_next = 1'b0;
      wrap_cnt_next  = '0;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
    seg7_decode #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_seg (
      .digit (bcd_q[4*g +: 4]),
      .seg   (hex_n[7*g +: 7])
    );
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign bcd       = bcd_q;
  assign wrap_flag = wrap_flag_q;
  assign wrap_cnt  = wrap_cnt_q;

endmodule
